// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with active-low strobes, registered active-low status flags
// and sticky error flags. Define PARAM_FIFO_OREG_EN for a registered read-data output.
module param_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = 6,
  parameter int AEMPTY_LVL = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             FClrN,
  input  logic             FInN,
  input  logic             FOutN,
  input  logic [WIDTH-1:0] Data_In,
  output logic [WIDTH-1:0] F_Data,
  output logic [CW-1:0]    F_Count,
  output logic             F_EmptyN,
  output logic             F_FullN,
  output logic             F_FirstN,
  output logic             F_LastN,
  output logic             F_SLastN,
  output logic             F_AFullN,
  output logic             F_AEmptyN,
  output logic             F_OvfN,
  output logic             F_UdfN
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty_n_q, empty_n_d;
  logic full_n_q, full_n_d;
  logic first_n_q, first_n_d;
  logic last_n_q, last_n_d;
  logic slast_n_q, slast_n_d;
  logic afull_n_q, afull_n_d;
  logic aempty_n_q, aempty_n_d;
  logic ovf_n_q, ovf_n_d;
  logic udf_n_q, udf_n_d;

  logic clr;
  logic wr_req, rd_req;
  logic is_full, is_empty;
  logic wr_acc, rd_acc;

  assign clr      = !FClrN;
  assign wr_req   = !FInN;
  assign rd_req   = !FOutN;
  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  // Clear swallows both strobes, so neither side is accepted in that cycle.
  assign wr_acc   = !clr && wr_req && !is_full;
  assign rd_acc   = !clr && rd_req && !is_empty;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_n_d  = ovf_n_q;
    udf_n_d  = udf_n_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_n_d  = 1'b1;
      udf_n_d  = 1'b1;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wr_req && is_full)  ovf_n_d = 1'b0;
      if (rd_req && is_empty) udf_n_d = 1'b0;
    end
  end

  // Flags are decoded from the next count so they always agree with F_Count.
  always_comb begin
    empty_n_d  = (count_d != '0);
    full_n_d   = (count_d != CW'(DEPTH));
    first_n_d  = (count_d != CW'(1));
    last_n_d   = (count_d != CW'(DEPTH - 1));
    slast_n_d  = (count_d != CW'(DEPTH - 2));
    afull_n_d  = !(count_d >= CW'(AFULL_LVL));
    aempty_n_d = !(count_d <= CW'(AEMPTY_LVL));
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_n_q  <= 1'b0;
      full_n_q   <= 1'b1;
      first_n_q  <= 1'b1;
      last_n_q   <= 1'b1;
      slast_n_q  <= 1'b1;
      afull_n_q  <= 1'b1;
      aempty_n_q <= 1'b0;
      ovf_n_q    <= 1'b1;
      udf_n_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_n_q  <= empty_n_d;
      full_n_q   <= full_n_d;
      first_n_q  <= first_n_d;
      last_n_q   <= last_n_d;
      slast_n_q  <= slast_n_d;
      afull_n_q  <= afull_n_d;
      aempty_n_q <= aempty_n_d;
      ovf_n_q    <= ovf_n_d;
      udf_n_q    <= udf_n_d;
    end
  end

  // Storage carries no reset; stale words are never visible past the pointers.
  always_ff @(posedge Clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= Data_In;
  end

`ifdef PARAM_FIFO_OREG_EN
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (rd_acc) data_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) data_q <= '0;
    else       data_q <= data_d;
  end

  assign F_Data = data_q;
`else
  assign F_Data = mem_q[rd_ptr_q];
`endif

  assign F_Count   = count_q;
  assign F_EmptyN  = empty_n_q;
  assign F_FullN   = full_n_q;
  assign F_FirstN  = first_n_q;
  assign F_LastN   = last_n_q;
  assign F_SLastN  = slast_n_q;
  assign F_AFullN  = afull_n_q;
  assign F_AEmptyN = aempty_n_q;
  assign F_OvfN    = ovf_n_q;
  assign F_UdfN    = udf_n_q;

endmodule
